// File: rtl/tpu_pkg.sv
// Shared TPU package: sequencer state type and host bus address map.
package tpu_pkg;

  // MatMul sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StFeed,
    StDone
  } mm_state_e;

  // Host bus region bases.
  localparam logic [15:0] AddrA      = 16'h0100;
  localparam logic [15:0] AddrB      = 16'h0200;
  localparam logic [15:0] AddrC      = 16'h0300;
  localparam logic [15:0] AddrMatMul = 16'h0400;

endpackage

// File: rtl/tpu_mm_seq.sv
// MatMul sequencer: clears the systolic array, streams the skewed A/B feed for
// FEED_CYCLES cycles, then pulses done. Flags protocol violations in a sticky err.
module tpu_mm_seq
  import tpu_pkg::*;
#(
  parameter int unsigned DIM         = 8,
  parameter int unsigned FEED_CYCLES = 3 * DIM - 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 host_wr,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic                                 sa_clr,
  output logic                                 memA_en,
  output logic                                 memB_en,
  output logic                                 sa_en,
  output logic [$clog2(FEED_CYCLES+1)-1:0]     feed_cnt
);

  localparam int unsigned CW = $clog2(FEED_CYCLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(FEED_CYCLES - 1);

  mm_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  // State, feed counter and sticky error; counter is zero everywhere but FEED.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // host_wr is legal here: the array is not busy yet.
          if (start) begin
            state_q <= StClear;
            err_q   <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
          cnt_q <= '0;
        end
        StClear: begin
          state_q <= StFeed;
          cnt_q   <= '0;
          if (start || host_wr) err_q <= 1'b1;
        end
        StFeed: begin
          if (cnt_q == CntLast) begin
            state_q <= StDone;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
          if (start || host_wr) err_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    sa_clr  = 1'b0;
    memA_en = 1'b0;
    memB_en = 1'b0;
    sa_en   = 1'b0;
    unique case (state_q)
      StClear: begin
        sa_clr = 1'b1;
        busy   = 1'b1;
      end
      StFeed: begin
        memA_en = 1'b1;
        memB_en = 1'b1;
        sa_en   = 1'b1;
        busy    = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign err      = err_q;
  assign feed_cnt = cnt_q;

endmodule

// File: tb/tb_tpu_mm_seq.sv
// Scoreboard bench for tpu_mm_seq at DIM = 8, 4 and 2 sharing one stimulus stream.
// Expected outputs come from a timeline model: each accepted start fixes a
// schedule (clear, FEED_CYCLES feed cycles, done) relative to its edge.
module tb_tpu_mm_seq;

  localparam int NCYC = 3000;
  localparam int NOSEQ = -100000;

  typedef struct packed {
    logic [2:0]      clr;
    logic [2:0]      feed;
    logic [2:0]      dn;
    logic [2:0]      bsy;
    logic [2:0]      er;
    logic [2:0][4:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, host_wr;

  logic [2:0] busy, done, err, sa_clr, mema, memb, saen;
  logic [4:0] fc8;
  logic [3:0] fc4;
  logic [2:0] fc2;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  tpu_mm_seq #(.DIM(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start), .host_wr(host_wr),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .sa_clr(sa_clr[0]),
    .memA_en(mema[0]), .memB_en(memb[0]), .sa_en(saen[0]), .feed_cnt(fc8)
  );
  tpu_mm_seq #(.DIM(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .host_wr(host_wr),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .sa_clr(sa_clr[1]),
    .memA_en(mema[1]), .memB_en(memb[1]), .sa_en(saen[1]), .feed_cnt(fc4)
  );
  tpu_mm_seq #(.DIM(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .host_wr(host_wr),
    .busy(busy[2]), .done(done[2]), .err(err[2]), .sa_clr(sa_clr[2]),
    .memA_en(mema[2]), .memB_en(memb[2]), .sa_en(saen[2]), .feed_cnt(fc2)
  );

  // Model: edge at which the current sequence was accepted, and expected err.
  int fcl[3] = '{22, 10, 4};
  int dims[3] = '{8, 4, 2};
  int seq_edge[3];
  bit err_m[3];

  // Apply inputs sampled at edge n+1 (interval n is current) and push the
  // expected outputs for interval n+1.
  task automatic step_model(input int n, input bit r, input bit s, input bit h);
    exp_t e;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      int dp;
      int d;
      bit bsy_now;
      dp = n - seq_edge[k];
      bsy_now = (dp >= 0) && (dp <= fcl[k]);
      if (!r) begin
        seq_edge[k] = NOSEQ;
        err_m[k] = 1'b0;
      end else if (s && !bsy_now) begin
        seq_edge[k] = n + 1;
        err_m[k] = 1'b0;
      end else if (bsy_now && (s || h)) begin
        err_m[k] = 1'b1;
      end
      d = n + 1 - seq_edge[k];
      e.clr[k]  = (d == 0);
      e.feed[k] = (d >= 1) && (d <= fcl[k]);
      e.cnt[k]  = e.feed[k] ? 5'(d - 1) : 5'd0;
      e.dn[k]   = (d == fcl[k] + 1);
      e.bsy[k]  = e.clr[k] | e.feed[k];
      e.er[k]   = err_m[k];
    end
    exp_q.push_back(e);
  endtask

  function automatic bit dir_start(input int n);
    return (n == 5) || (n == 15) || (n == 29) || (n == 60) || (n == 72);
  endfunction

  // Stimulus: directed prologue, then random traffic.
  initial begin
    bit r, s, h;
    for (int k = 0; k < 3; k++) begin
      seq_edge[k] = NOSEQ;
      err_m[k] = 1'b0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    host_wr = 1'b0;
    step_model(0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      if (n < 100) begin
        r = !((n <= 2) || (n == 70));
        s = dir_start(n);
        h = (n == 10) || (n == 56) || (n == 64);
      end else begin
        r = ($urandom_range(0, 99) != 0);
        s = ($urandom_range(0, 6) == 0);
        h = ($urandom_range(0, 7) == 0);
      end
      rst_n = r;
      start = s;
      host_wr = h;
      step_model(n, r, s, h);
    end
    @(posedge clk);
    stim_done = 1'b1;
  end

  // Monitor: one expected record per interval, compared mid-cycle.
  initial begin
    exp_t e;
    logic [2:0][4:0] cnt_act;
    bit feed_act;
    bit alias_ok;
    while (!stim_done) begin
      @(negedge clk);
      if (stim_done) break;
      cnt_act[0] = fc8;
      cnt_act[1] = {1'b0, fc4};
      cnt_act[2] = {2'b0, fc2};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t: no expected record", $time);
        continue;
      end
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        feed_act = mema[k];
        alias_ok = (mema[k] == memb[k]) && (mema[k] == saen[k]);
        checks++;
        if (sa_clr[k] !== e.clr[k] || feed_act !== e.feed[k] || !alias_ok ||
            done[k] !== e.dn[k] || busy[k] !== e.bsy[k] || err[k] !== e.er[k] ||
            cnt_act[k] !== e.cnt[k]) begin
          errors++;
          $display("FAIL outputs dim%0d at %0t: got clr=%b en=%b%b%b done=%b busy=%b err=%b cnt=%0d, exp clr=%b en=%b done=%b busy=%b err=%b cnt=%0d",
                   dims[k], $time, sa_clr[k], mema[k], memb[k], saen[k], done[k], busy[k],
                   err[k], cnt_act[k], e.clr[k], e.feed[k], e.dn[k], e.bsy[k], e.er[k],
                   e.cnt[k]);
        end
        checks++;
        if (!$onehot0({sa_clr[k], mema[k], done[k]}) ||
            !$onehot0({sa_clr[k], memb[k], done[k]}) ||
            !$onehot0({sa_clr[k], saen[k], done[k]})) begin
          errors++;
          $display("FAIL exclusive dim%0d at %0t: got clr=%b en=%b%b%b done=%b, exp at most one",
                   dims[k], $time, sa_clr[k], mema[k], memb[k], saen[k], done[k]);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
